// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo family.
package sync_fifo_pkg;

    // Read-side presentation mode of the FIFO.
    typedef enum logic {
        REGISTERED   = 1'b0,
        FALL_THROUGH = 1'b1
    } fwft_mode_e;

    // The fill count must represent 0..DEPTH inclusive, so it needs one bit more than the pointers.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port and one asynchronous read port.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted write.
    // NOTE: the array has no reset; clearing it would prevent RAM inference, and stale data is never visible because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, threshold flags, sticky error flags and selectable FWFT read mode.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [count_width(ADDR_WIDTH)-1:0] count,
    input  logic                               clr_err,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam int         CW    = count_width(ADDR_WIDTH);
    localparam fwft_mode_e MODE  = (FWFT != 0) ? FALL_THROUGH : REGISTERED;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    // Reject illegal configurations at elaboration.
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("sync_fifo: ADDR_WIDTH must be at least 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  mem_we;

    // Acceptance is decided on the pre-edge flags; nothing is accepted while reset is asserted.
    assign wr_ok  = wr_en & ~full;
    assign rd_ok  = rd_en & ~empty;
    assign mem_we = wr_ok & rst_n;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rdata)
    );

    // Next fill level: a simultaneous write and read leave the count unchanged.
    always_comb begin
        // NOTE: default assigned first so every path drives count_next and no latch is inferred.
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow <= 1'b1;
            else if (clr_err)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;
        end
    end

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    if (MODE == REGISTERED) begin : g_registered
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        // Registered read: data is presented for one cycle after an accepted read, then held.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) data_q <= mem_rdata;
            end
        end

        assign data_out = data_q;
        assign rd_valid = valid_q;
    end else begin : g_fall_through
        assign data_out = mem_rdata;
        assign rd_valid = ~empty;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: scoreboard queue plus directed steps for both read modes.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en = 1'b0;
    logic [7:0] f_data_in = '0;
    logic       f_rd_en = 1'b0;
    logic [7:0] f_data_out;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int passed = 0;
    int total  = 0;

    logic [7:0] q[$];
    logic       ovf_m = 1'b0;
    logic       unf_m = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_dout = '0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)
    ) dut_ft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .clr_err(1'b0), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare every registered-mode output against the scoreboard model.
    task automatic check_status();
        int n;
        n = q.size();
        check("count",        32'(count),        32'(n));
        check("full",         32'(full),         32'(n == 16));
        check("empty",        32'(empty),        32'(n == 0));
        check("almost_full",  32'(almost_full),  32'(n >= 12));
        check("almost_empty", 32'(almost_empty), 32'(n <= 2));
        check("overflow",     32'(overflow),     32'(ovf_m));
        check("underflow",    32'(underflow),    32'(unf_m));
        check("rd_valid",     32'(rd_valid),     32'(exp_valid));
        check("data_out",     32'(data_out),     32'(exp_dout));
    endtask

    // One clock of stimulus on the registered-mode FIFO, with the model updated from pre-edge state.
    task automatic do_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic full_m, empty_m;
        @(negedge clk);
        wr_en = w; data_in = d; rd_en = r; clr_err = c;
        full_m  = (q.size() == 16);
        empty_m = (q.size() == 0);
        if (r && !empty_m) begin
            exp_dout  = q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (w && !full_m) q.push_back(d);
        if (w && full_m) ovf_m = 1'b1;
        else if (c)      ovf_m = 1'b0;
        if (r && empty_m) unf_m = 1'b1;
        else if (c)       unf_m = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_status();
    endtask

    // Hold reset for n edges with a write request active; the request must be ignored.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b1; data_in = 8'h77;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        ovf_m = 1'b0; unf_m = 1'b0; exp_valid = 1'b0; exp_dout = 8'h00;
        check_status();
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
    endtask

    initial begin
        // Reset with wr_en held high.
        do_reset(2);
        check("ft_empty_after_reset", 32'(f_empty), 32'd1);
        check("ft_valid_after_reset", 32'(f_rd_valid), 32'd0);

        // Fill 0x00..0x0F, then an overflowing write of 0xAA.
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        // Drain all 16 and one idle cycle so rd_valid must drop.
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Clear the overflow flag.
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous access when full: read wins, write rejected.
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous access when empty: write wins, read rejected.
        do_cycle(1'b1, 8'h55, 1'b1, 1'b0);

        // Simultaneous access at count 5 keeps count and order.
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);

        // Continuous traffic at count 3 across pointer wrap.
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) do_cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);

        // Drain, then clr_err together with a new underflow: the set must win.
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset at count 7 discards data; a following read underflows.
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_reset(1);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // First-word-fall-through instance.
        f_wr_en = 1'b1; f_data_in = 8'h5C;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        f_wr_en = 1'b0;
        check("ft_data_out_5c", 32'(f_data_out), 32'h5C);
        check("ft_rd_valid_set", 32'(f_rd_valid), 32'd1);
        check("ft_count_1", 32'(f_count), 32'd1);
        f_rd_en = 1'b1;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        f_rd_en = 1'b0;
        check("ft_empty_after_pop", 32'(f_empty), 32'd1);
        check("ft_rd_valid_clear", 32'(f_rd_valid), 32'd0);
        check("ft_count_0", 32'(f_count), 32'd0);
        f_wr_en = 1'b1; f_data_in = 8'h11;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        f_data_in = 8'h22;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        f_wr_en = 1'b0;
        check("ft_head_11", 32'(f_data_out), 32'h11);
        f_rd_en = 1'b1;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        f_rd_en = 1'b0;
        check("ft_head_22", 32'(f_data_out), 32'h22);
        check("ft_valid_one_left", 32'(f_rd_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
